// File: rtl/weight_fetch_unit.sv
// Weight fetch unit: streams weight tiles from weight memory into the weight FIFO.
// Rows within each tile go out bottom-first, and read credits keep the FIFO from overflowing.
module weight_fetch_unit #(
  parameter int MUL_SIZE   = 32,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [4:0]                 u_tiles_i,
  input  logic [4:0]                 iter_tiles_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       mem_rd_en_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [MUL_SIZE*DATA_W-1:0] mem_rdata_i,
  output logic                       fifo_wr_en_o,
  output logic [MUL_SIZE*DATA_W-1:0] fifo_wdata_o,
  output logic                       fifo_wlast_o,
  input  logic                       fifo_pop_i
);

  localparam int ROW_W  = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(MUL_SIZE - 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [9:0]          total_q;
  logic [9:0]          tile_q;
  logic [ROW_W-1:0]    row_q;
  logic [CRED_W-1:0]   credits_q;
  logic [CRED_W-1:0]   credits_d;
  logic [CRED_W:0]     cred_sum;
  logic [MEM_LAT-1:0]  valid_q;
  logic [MEM_LAT-1:0]  valid_d;
  logic [MEM_LAT-1:0]  valid_shift;
  logic [MEM_LAT-1:0]  last_q;
  logic [MEM_LAT-1:0]  last_d;
  logic                done_q;
  logic                done_d;
  logic                issue;
  logic                row_end;
  logic                final_row;
  logic                pipe_drained;
  logic [9:0]          start_total;
  logic [ADDR_W-1:0]   row_addr;

  assign start_total = 10'(u_tiles_i) * 10'(iter_tiles_i);
  assign row_end     = (row_q == ROW_LAST);
  assign final_row   = row_end && (tile_q == (total_q - 10'd1));

  // The pipe is empty next cycle once everything below the tail has shifted out.
  assign valid_shift  = valid_q << 1;
  assign pipe_drained = (valid_shift == '0);
  assign valid_d      = valid_shift | MEM_LAT'(issue);
  assign last_d       = (last_q << 1) | MEM_LAT'(issue && row_end);

  assign row_addr = base_q
                  + ADDR_W'(tile_q) * ADDR_W'(MUL_SIZE)
                  + (ADDR_W'(MUL_SIZE - 1) - ADDR_W'(row_q));

  assign cred_sum  = {1'b0, credits_q} + (CRED_W+1)'(fifo_pop_i) - (CRED_W+1)'(issue);
  assign credits_d = (cred_sum > {1'b0, CRED_MAX}) ? CRED_MAX : cred_sum[CRED_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_total == 10'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (credits_q != '0) begin
          issue = 1'b1;
          if (final_row) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_drained) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Job fields are only latched from IDLE, so a start during a job has no effect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q    <= '0;
      total_q   <= '0;
      tile_q    <= '0;
      row_q     <= '0;
      credits_q <= CRED_MAX;
      valid_q   <= '0;
      last_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      credits_q <= credits_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      if ((state_q == IDLE) && start_i) begin
        base_q  <= base_addr_i;
        total_q <= start_total;
        tile_q  <= '0;
        row_q   <= '0;
      end else if (issue) begin
        if (row_end) begin
          row_q  <= '0;
          tile_q <= tile_q + 10'd1;
        end else begin
          row_q  <= row_q + ROW_W'(1);
        end
      end
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign mem_rd_en_o  = issue;
  assign mem_addr_o   = issue ? row_addr : '0;
  assign fifo_wr_en_o = valid_q[MEM_LAT-1];
  assign fifo_wlast_o = last_q[MEM_LAT-1];
  assign fifo_wdata_o = mem_rdata_i;

  // A pop with every credit home means the consumer popped an empty FIFO.
  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_pop_i && (credits_q == CRED_MAX)));

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Bench for weight_fetch_unit: directed jobs feed address/row scoreboards that a negedge monitor drains.
// A latency-2 memory model returns an address-derived row for each read.
module tb_weight_fetch_unit;

  localparam int MUL_SIZE   = 32;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 16;
  localparam int MEM_LAT    = 2;
  localparam int FIFO_DEPTH = 64;
  localparam int ROW_BITS   = MUL_SIZE * DATA_W;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                start_i;
  logic [ADDR_W-1:0]   base_addr_i;
  logic [4:0]          u_tiles_i;
  logic [4:0]          iter_tiles_i;
  logic                busy_o;
  logic                done_o;
  logic                mem_rd_en_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [ROW_BITS-1:0] mem_rdata_i;
  logic                fifo_wr_en_o;
  logic [ROW_BITS-1:0] fifo_wdata_o;
  logic                fifo_wlast_o;
  logic                fifo_pop_i;

  weight_fetch_unit #(
    .MUL_SIZE(MUL_SIZE), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .u_tiles_i(u_tiles_i), .iter_tiles_i(iter_tiles_i), .busy_o(busy_o), .done_o(done_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_wdata_o(fifo_wdata_o), .fifo_wlast_o(fifo_wlast_o),
    .fifo_pop_i(fifo_pop_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [ROW_BITS-1:0] rowData(input logic [ADDR_W-1:0] a);
    return {(ROW_BITS/ADDR_W){a ^ 16'hA5C3}};
  endfunction

  // Weight memory model: data for the address strobed at cycle c appears at cycle c+2.
  logic [ADDR_W-1:0] mem_pipe0, mem_pipe1;
  always @(posedge clk_i) begin
    mem_pipe0 <= mem_addr_o;
    mem_pipe1 <= mem_pipe0;
  end
  assign mem_rdata_i = rowData(mem_pipe1);

  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [ADDR_W:0]   exp_wr_q[$];

  int  job_start = 0, job_issues = 0, job_writes = 0;
  int  first_rd = -1, first_wr = -1, last_rd = 0;
  int  done_count = 0, done_rel = 0, done_base = 0;
  int  occ = 0, live_issues = 0, live_pops = 0;
  int  start_cyc = 0, pop_cyc = 0;
  bit  auto_pop = 1'b0, force_pop = 1'b0;

  task automatic checkOutput(input string name, input logic [ROW_BITS-1:0] actual,
                             input logic [ROW_BITS-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: samples mid-cycle and settles every DUT output event against the scoreboards.
  always @(negedge clk_i) begin
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W:0]   ew;
    if (start_i && !busy_o && !rst_i) begin
      job_start  = cyc;
      job_issues = 0;
      job_writes = 0;
      first_rd   = -1;
      first_wr   = -1;
    end
    if (mem_rd_en_o) begin
      if (job_issues == 0) first_rd = cyc - job_start;
      job_issues++;
      live_issues++;
      last_rd = cyc;
      if (exp_rd_q.size() == 0) begin
        checkOutput("rd_unexpected", 1, 0);
      end else begin
        ea = exp_rd_q.pop_front();
        checkOutput("rd_addr", mem_addr_o, ea);
      end
      checkOutput("credit_bound", (live_issues - live_pops) > FIFO_DEPTH, 0);
    end
    if (fifo_wr_en_o) begin
      if (job_writes == 0) first_wr = cyc - job_start;
      job_writes++;
      occ++;
      if (exp_wr_q.size() == 0) begin
        checkOutput("wr_unexpected", 1, 0);
      end else begin
        ew = exp_wr_q.pop_front();
        checkOutput("wr_data", fifo_wdata_o, rowData(ew[ADDR_W-1:0]));
        checkOutput("wr_last", fifo_wlast_o, ew[ADDR_W]);
      end
    end
    if (fifo_pop_i) begin
      occ--;
      live_pops++;
    end
    if (done_o) begin
      done_count++;
      done_rel = cyc - job_start;
      checkOutput("busy_at_done", busy_o, 0);
    end
    if (rst_i) begin
      occ         = 0;
      live_issues = 0;
      live_pops   = 0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    fifo_pop_i = (auto_pop && occ > 0) || force_pop;
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [4:0] ut,
                               input logic [4:0] it);
    logic [ADDR_W-1:0] a;
    tick();
    start_i      = 1'b1;
    base_addr_i  = b;
    u_tiles_i    = ut;
    iter_tiles_i = it;
    start_cyc    = cyc;
    done_base    = done_count;
    for (int t = 0; t < int'(ut) * int'(it); t++) begin
      for (int r = 0; r < MUL_SIZE; r++) begin
        a = b + ADDR_W'(t * MUL_SIZE + MUL_SIZE - 1 - r);
        exp_rd_q.push_back(a);
        exp_wr_q.push_back({(r == MUL_SIZE - 1), a});
      end
    end
    tick();
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done_count == done_base && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_seen", done_count != done_base, 1);
  endtask

  task automatic drainFifo();
    int n = 0;
    auto_pop = 1'b1;
    while (occ > 0 && n < 300) begin
      tick();
      n++;
    end
    tick();
    checkOutput("fifo_drained", occ, 0);
  endtask

  task automatic checkQueuesEmpty();
    checkOutput("rd_queue_empty", exp_rd_q.size(), 0);
    checkOutput("wr_queue_empty", exp_wr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    base_addr_i  = '0;
    u_tiles_i    = '0;
    iter_tiles_i = '0;
    fifo_pop_i   = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs", {busy_o, done_o, mem_rd_en_o, fifo_wr_en_o, fifo_wlast_o}, 0);
    checkOutput("reset_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    tick();

    // 1x1 tile, consumer keeps up: 0x011F..0x0100 on cycles 1..32, done at 35.
    auto_pop = 1'b1;
    applyStimulus(16'h0100, 5'd1, 5'd1);
    waitDone(200);
    checkOutput("t1_done_cycle", done_rel, 35);
    checkOutput("t1_first_rd", first_rd, 1);
    checkOutput("t1_first_wr", first_wr, 3);
    checkOutput("t1_writes", job_writes, 32);
    checkQueuesEmpty();
    drainFifo();

    // Zero-tile job: done one cycle after start with no traffic.
    applyStimulus(16'h0200, 5'd0, 5'd5);
    waitDone(10);
    checkOutput("t3_done_cycle", done_rel, 1);
    repeat (5) tick();
    checkOutput("t3_issues", job_issues, 0);
    checkOutput("t3_writes", job_writes, 0);

    // Second start at cycle 10 with a different base must be ignored.
    applyStimulus(16'h2000, 5'd1, 5'd1);
    while (cyc - start_cyc < 10) tick();
    start_i      = 1'b1;
    base_addr_i  = 16'h3000;
    u_tiles_i    = 5'd2;
    iter_tiles_i = 5'd1;
    tick();
    start_i = 1'b0;
    waitDone(200);
    checkOutput("t5_done_cycle", done_rel, 35);
    repeat (10) tick();
    checkOutput("t5_issues", job_issues, 32);
    checkOutput("t5_busy_after", busy_o, 0);
    checkQueuesEmpty();
    drainFifo();

    // 1x3 tiles without pops: credits run out after 64 issues.
    auto_pop = 1'b0;
    applyStimulus(16'h0100, 5'd3, 5'd1);
    repeat (100) tick();
    checkOutput("t2_stall_issues", job_issues, 64);
    checkOutput("t2_stall_rd_en", mem_rd_en_o, 0);
    force_pop = 1'b1;
    tick();
    pop_cyc   = cyc;
    force_pop = 1'b0;
    repeat (5) tick();
    checkOutput("t2_single_pop_issues", job_issues, 65);
    checkOutput("t2_issue_after_pop", last_rd, pop_cyc + 1);
    // Pops overlapping issues at zero credit: three pops buy exactly three reads.
    force_pop = 1'b1;
    repeat (3) tick();
    force_pop = 1'b0;
    repeat (5) tick();
    checkOutput("t4_burst_issues", job_issues, 68);
    auto_pop = 1'b1;
    waitDone(400);
    checkOutput("t2_writes", job_writes, 96);
    checkQueuesEmpty();
    drainFifo();

    // Reset at cycle 20 of a 2-tile job, then rerun it with no pops.
    applyStimulus(16'h0400, 5'd2, 5'd1);
    while (cyc - start_cyc < 20) tick();
    rst_i    = 1'b1;
    auto_pop = 1'b0;
    tick();
    rst_i = 1'b0;
    checkOutput("t6_rst_outputs", {busy_o, done_o, mem_rd_en_o, fifo_wr_en_o, fifo_wlast_o}, 0);
    checkOutput("t6_rst_addr", mem_addr_o, 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    tick();
    applyStimulus(16'h0400, 5'd2, 5'd1);
    waitDone(200);
    checkOutput("t6_done_cycle", done_rel, 67);
    checkOutput("t6_writes", job_writes, 64);
    checkQueuesEmpty();
    drainFifo();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_fetch_unit.md
# weight_fetch_unit

Fetches weight tiles from on-chip weight memory and pushes them row by row into the weight FIFO, which feeds the weight control unit and systolic-array weight loading. For each MAC instruction it walks `u_tiles_i × iter_tiles_i` tiles of MUL_SIZE rows each. Within a tile, rows are issued bottom-first so the top row arrives last. Credit-based flow control guarantees the FIFO never overflows despite the fixed memory read latency.

## Interface
- MUL_SIZE, 32, systolic-array dimension (rows per tile, elements per row)
- DATA_W, 8, bits per weight element
- ADDR_W, 16, weight-memory row address width
- MEM_LAT, 2, fixed read latency of weight memory in cycles (≥1)
- FIFO_DEPTH, 64, weight FIFO depth in rows; initial credit count
- clk_i  in  1  clock, all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle pulse starting a fetch job; fields below sampled with it
- base_addr_i  in  ADDR_W  row address of tile 0, row 0
- u_tiles_i  in  5  U_dim>>5
- iter_tiles_i  in  5  ITER_dim>>5
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse: all rows of job written to FIFO
- mem_rd_en_o  out  1  weight-memory read strobe
- mem_addr_o  out  ADDR_W  read address
- mem_rdata_i  in  MUL_SIZE*DATA_W  read data, valid MEM_LAT cycles after strobe
- fifo_wr_en_o  out  1  FIFO push
- fifo_wdata_o  out  MUL_SIZE*DATA_W  pushed row (= mem_rdata_i passthrough)
- fifo_wlast_o  out  1  pushed row is the last row of its tile
- fifo_pop_i  in  1  consumer popped one row (returns one credit)

## Operation
- States: IDLE, FETCH, DRAIN. Reset → IDLE; all outputs 0; credits = FIFO_DEPTH; tile/row counters, in-flight pipe cleared.
- IDLE: on start_i, latch base, total_tiles = u_tiles_i*iter_tiles_i (10 bits, max 961). If total_tiles == 0, pulse done_o next cycle and stay IDLE; otherwise → FETCH, busy_o=1.
- FETCH: each cycle with credits > 0, issue one read: mem_addr_o = base + tile*MUL_SIZE + (MUL_SIZE-1-row), row counting 0..MUL_SIZE-1, then tile++. Addition wraps modulo 2^ADDR_W. After issuing the final row of the final tile → DRAIN.
- Credits: −1 per issue, +1 per fifo_pop_i. Issue and pop in the same cycle leave credits unchanged. A pop with credits == FIFO_DEPTH is illegal (assertion); credits saturate.
- Return path: MEM_LAT-deep valid shift register, plus a parallel last-row flag. fifo_wr_en_o = valid tail, fifo_wlast_o = flag tail, fifo_wdata_o = mem_rdata_i (combinational).
- DRAIN: no issues. When the pipe is empty, pulse done_o and → IDLE, busy_o=0.
- start_i while busy_o=1 is ignored (no latch, no effect on the current job).
- rst_i mid-job: in-flight reads are discarded and credits return to FIFO_DEPTH. The weight FIFO must be reset in the same cycle.

## Timing
- start_i sampled at cycle 0. First mem_rd_en_o at cycle 1, first fifo_wr_en_o at cycle 1+MEM_LAT.
- With no stalls, rows issue one per cycle. For N = total_tiles*MUL_SIZE rows: last issue at cycle N, last write at cycle N+MEM_LAT, done_o at cycle N+MEM_LAT+1, busy_o falls with done_o.
- Zero-tile job: done_o at cycle 1, no memory or FIFO activity.
- A credit returned by a pop at cycle k permits an issue at cycle k+1 (credit register update, no combinational pop→issue path).
- A new start_i is accepted in the same cycle done_o is high (state is IDLE).

## Test plan
- 1×1 tile, base=0x0100, MEM_LAT=2, pops keep credits high → addresses 0x011F down to 0x0100 on cycles 1..32; writes on cycles 3..34, wlast only on cycle 34; done_o on cycle 35.
- 1×3 tiles, no pops, FIFO_DEPTH=64 → exactly 64 issues, then mem_rd_en_o stays low. Pop one row at cycle k → next issue at cycle k+1, address 0x0100+64+31. Run to completion with 96 writes and wlast on rows 32/64/96.
- u_tiles_i=0 → done_o at cycle 1; mem_rd_en_o and fifo_wr_en_o never asserted.
- Credits=0 with simultaneous pop and start of issue window → credits stay consistent: count reads issued minus pops never exceeds FIFO_DEPTH (scoreboard).
- Second start_i mid-job with different base → ignored; address sequence and done_o timing match the first job only.
- rst_i asserted at cycle 20 of a 2-tile job → next cycle all outputs 0, state IDLE, credits 64. A fresh start afterwards produces the full, correct sequence from row 0.
